rcpu_mem_arbiter: RTL and testbench

- Shares the single external memory port between the rcpu core (master 0) and an auxiliary master (master 1, e.g. DMA or video fetch).
- Sits between rcpu's memAddr/memRead/memWrite/memRE/memWE/memReady pins and the memory.
- Grants one master per access and holds the grant until the memory completes.
- Throttles the loser through its ready signal.
- Default policy is CPU priority with a bounded aux wait counter for starvation protection.

---
 rtl/rcpu_mem_arbiter_pkg.sv | 34 +++
 rtl/rcpu_mem_arbiter_if.sv | 16 +
 rtl/rcpu_arb_mux.sv | 51 +++++
 rtl/rcpu_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_rcpu_mem_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/rcpu_mem_arbiter_pkg.sv
// Shared encodings for the rcpu external memory arbiter: FSM states,
// grant selectors, debug owner codes and master indices.
package rcpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'b00,
    ARB_LOCK_CPU = 2'b01,
    ARB_LOCK_AUX = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_AUX  = 2'b10
  } grant_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_CPU  = 2'b01;
  localparam logic [1:0] OWNER_AUX  = 2'b10;

  localparam int MST_CPU = 0;
  localparam int MST_AUX = 1;

  function automatic logic [1:0] owner_of(input arb_state_e state);
    logic [1:0] code;
    case (state)
      ARB_LOCK_CPU: code = OWNER_CPU;
      ARB_LOCK_AUX: code = OWNER_AUX;
      default:      code = OWNER_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rcpu_mem_arbiter_if.sv
// One memory access port: the master drives address/data/enables and the
// slave returns read data plus a completion strobe.
interface rcpu_mem_arbiter_if #(
  parameter int N = 32,
  parameter int M = 16
);
  logic [N-1:0] addr;
  logic [M-1:0] wdata;
  logic         re;
  logic         we;
  logic [M-1:0] rdata;
  logic         ready;

  modport master (output addr, wdata, re, we, input rdata, ready);
  modport slave  (input addr, wdata, re, we, output rdata, ready);
endinterface

// File: rtl/rcpu_arb_mux.sv
// Combinational 2:1 bus select onto the memory port; an idle grant parks
// the bus at zero and a write always suppresses the read enable.
module rcpu_arb_mux
  import rcpu_mem_arbiter_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 16
) (
  input  grant_e       grant_i,
  input  logic [N-1:0] cpu_addr_i,
  input  logic [M-1:0] cpu_wdata_i,
  input  logic         cpu_re_i,
  input  logic         cpu_we_i,
  input  logic [N-1:0] aux_addr_i,
  input  logic [M-1:0] aux_wdata_i,
  input  logic         aux_re_i,
  input  logic         aux_we_i,
  output logic [N-1:0] mem_addr_o,
  output logic [M-1:0] mem_wdata_o,
  output logic         mem_re_o,
  output logic         mem_we_o
);

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    case (grant_i)
      GNT_CPU: begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_re_o    = cpu_re_i & ~cpu_we_i;
        mem_we_o    = cpu_we_i;
      end
      GNT_AUX: begin
        mem_addr_o  = aux_addr_i;
        mem_wdata_o = aux_wdata_i;
        mem_re_o    = aux_re_i & ~aux_we_i;
        mem_we_o    = aux_we_i;
      end
      default: begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rcpu_mem_arbiter.sv
// Shares one memory port between the rcpu core and an auxiliary master:
// CPU priority, grant held until completion, bounded aux starvation.
module rcpu_mem_arbiter
  import rcpu_mem_arbiter_pkg::*;
#(
  parameter int N            = 32,
  parameter int M            = 16,
  parameter int AUX_MAX_WAIT = 8,
  parameter int WAIT_W       = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rcpu_mem_arbiter_if.slave   cpu,
  rcpu_mem_arbiter_if.slave   aux,
  rcpu_mem_arbiter_if.master  mem,
  output logic [1:0]          owner_o
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(AUX_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  arb_state_e        state_q, state_d;
  grant_e            grant_s;
  logic [1:0]        req_s;
  logic              cpu_ready_s, aux_ready_s;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        owner_q, owner_d;

  assign req_s[MST_CPU] = cpu.re | cpu.we;
  assign req_s[MST_AUX] = aux.re | aux.we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
      owner_q <= OWNER_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      owner_q <= owner_d;
    end
  end

  // A lock ends on completion or when its master withdraws the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_s == GNT_CPU && !mem.ready) begin
          state_d = ARB_LOCK_CPU;
        end else if (grant_s == GNT_AUX && !mem.ready) begin
          state_d = ARB_LOCK_AUX;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCK_CPU: begin
        if (!req_s[MST_CPU] || mem.ready) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_LOCK_CPU;
        end
      end
      ARB_LOCK_AUX: begin
        if (!req_s[MST_AUX] || mem.ready) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_LOCK_AUX;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    owner_d = owner_of(state_d);
  end

  // Idle-state selection is combinational so a grant costs no extra cycle.
  always_comb begin
    grant_s = GNT_NONE;
    if (rst_i) begin
      grant_s = GNT_NONE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (req_s[MST_AUX] && (!req_s[MST_CPU] || wait_q >= WAIT_LIMIT)) begin
            grant_s = GNT_AUX;
          end else if (req_s[MST_CPU]) begin
            grant_s = GNT_CPU;
          end else begin
            grant_s = GNT_NONE;
          end
        end
        ARB_LOCK_CPU: grant_s = req_s[MST_CPU] ? GNT_CPU : GNT_NONE;
        ARB_LOCK_AUX: grant_s = req_s[MST_AUX] ? GNT_AUX : GNT_NONE;
        default:      grant_s = GNT_NONE;
      endcase
    end
    // An idle master reads ready high so rcpu never stalls without memRE.
    cpu_ready_s = !rst_i && (!req_s[MST_CPU] || (grant_s == GNT_CPU && mem.ready));
    aux_ready_s = !rst_i && (!req_s[MST_AUX] || (grant_s == GNT_AUX && mem.ready));
  end

  always_comb begin
    wait_d = '0;
    if (req_s[MST_AUX] && !aux_ready_s) begin
      wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WAIT_ONE;
    end else begin
      wait_d = '0;
    end
  end

  rcpu_arb_mux #(.N(N), .M(M)) u_mux (
    .grant_i     (grant_s),
    .cpu_addr_i  (cpu.addr),
    .cpu_wdata_i (cpu.wdata),
    .cpu_re_i    (cpu.re),
    .cpu_we_i    (cpu.we),
    .aux_addr_i  (aux.addr),
    .aux_wdata_i (aux.wdata),
    .aux_re_i    (aux.re),
    .aux_we_i    (aux.we),
    .mem_addr_o  (mem.addr),
    .mem_wdata_o (mem.wdata),
    .mem_re_o    (mem.re),
    .mem_we_o    (mem.we)
  );

  assign cpu.rdata = mem.rdata;
  assign aux.rdata = mem.rdata;
  assign cpu.ready = cpu_ready_s;
  assign aux.ready = aux_ready_s;
  assign owner_o   = owner_q;

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Directed bench for rcpu_mem_arbiter: the driver queues the expected bus
// state for each cycle, a negedge monitor pops and compares it.
module tb_rcpu_mem_arbiter;

  localparam int N = 32;
  localparam int M = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] owner;

  rcpu_mem_arbiter_if #(.N(N), .M(M)) cpu_if ();
  rcpu_mem_arbiter_if #(.N(N), .M(M)) aux_if ();
  rcpu_mem_arbiter_if #(.N(N), .M(M)) mem_if ();

  rcpu_mem_arbiter #(.N(N), .M(M), .AUX_MAX_WAIT(8), .WAIT_W(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cpu     (cpu_if),
    .aux     (aux_if),
    .mem     (mem_if),
    .owner_o (owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        re;
    logic        we;
    logic        crdy;
    logic        ardy;
    logic        chk_ardy;
    logic [1:0]  owner;
    logic [15:0] rdata;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Queue one cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic [31:0] a, input logic [15:0] wd,
                     input logic re, input logic we, input logic cr, input logic ar,
                     input logic ca, input logic [1:0] own);
    exp_t e;
    e.addr = a; e.wdata = wd; e.re = re; e.we = we;
    e.crdy = cr; e.ardy = ar; e.chk_ardy = ca; e.owner = own;
    e.rdata = mem_if.rdata;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    mem_if.rdata = mem_if.rdata + 16'h0111;
  endtask

  task automatic idle();
    cpu_if.re = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = 32'h0; cpu_if.wdata = 16'h0;
    aux_if.re = 1'b0; aux_if.we = 1'b0; aux_if.addr = 32'h0; aux_if.wdata = 16'h0;
    mem_if.ready = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "mem_addr",  mem_if.addr, e.addr);
      chk(nm, "mem_wdata", {16'h0, mem_if.wdata}, {16'h0, e.wdata});
      chk(nm, "mem_re",    {31'h0, mem_if.re}, {31'h0, e.re});
      chk(nm, "mem_we",    {31'h0, mem_if.we}, {31'h0, e.we});
      chk(nm, "cpu_ready", {31'h0, cpu_if.ready}, {31'h0, e.crdy});
      if (e.chk_ardy) begin
        chk(nm, "aux_ready", {31'h0, aux_if.ready}, {31'h0, e.ardy});
      end
      chk(nm, "owner",     {30'h0, owner}, {30'h0, e.owner});
      chk(nm, "cpu_rdata", {16'h0, cpu_if.rdata}, {16'h0, e.rdata});
      chk(nm, "aux_rdata", {16'h0, aux_if.rdata}, {16'h0, e.rdata});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    mem_if.rdata = 16'h1000;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset cycle: requests ignored, nothing granted.
    cpu_if.re = 1'b1; cpu_if.addr = 32'h0000_0055;
    cyc("rst_hold", 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    rst = 1'b0;

    // CPU-only single-cycle read.
    idle();
    cpu_if.re = 1'b1; cpu_if.addr = 32'h0000_1234; mem_if.ready = 1'b1;
    cyc("cpu_rd", 32'h0000_1234, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    idle();
    cyc("idle1", 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);

    // CPU write with three wait states; aux requests during the lock.
    cpu_if.we = 1'b1; cpu_if.addr = 32'h0000_2000; cpu_if.wdata = 16'hBEEF;
    cyc("ws_start", 32'h0000_2000, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    aux_if.re = 1'b1; aux_if.addr = 32'h0000_3000;
    cyc("ws_lock1", 32'h0000_2000, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    cyc("ws_lock2", 32'h0000_2000, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    mem_if.ready = 1'b1;
    cyc("ws_done",  32'h0000_2000, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
    idle();
    cyc("idle2", 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);

    // Contention: CPU wins eight times, then aux gets one slot.
    cpu_if.re = 1'b1; aux_if.re = 1'b1; aux_if.addr = 32'h0000_8000; mem_if.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cpu_if.addr = 32'h0000_0100 + 32'(k);
      cyc("cpu_prio", 32'h0000_0100 + 32'(k), 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    end
    cpu_if.addr = 32'h0000_0200;
    cyc("aux_wins",  32'h0000_8000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    cyc("cpu_after", 32'h0000_0200, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    idle();
    cyc("idle3", 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);

    // Aux abort while locked; pending CPU request is granted next cycle.
    aux_if.re = 1'b1; aux_if.addr = 32'h0000_4444;
    cyc("abort_grant", 32'h0000_4444, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    aux_if.re = 1'b0; cpu_if.re = 1'b1; cpu_if.addr = 32'h0000_5555;
    cyc("abort", 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    mem_if.ready = 1'b1;
    cyc("abort_cpu", 32'h0000_5555, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    idle();
    cyc("idle4", 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);

    // Long aux lock drives wait count past the limit, then reset clears it.
    aux_if.we = 1'b1; aux_if.addr = 32'h0000_6000; aux_if.wdata = 16'h1111;
    cyc("rl_grant", 32'h0000_6000, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    for (int k = 0; k < 9; k++) begin
      cyc("rl_lock", 32'h0000_6000, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
    end
    rst = 1'b1; cpu_if.re = 1'b1; cpu_if.addr = 32'h0000_7000;
    cyc("rl_reset", 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    rst = 1'b0; mem_if.ready = 1'b1;
    cyc("rl_cpu", 32'h0000_7000, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    idle();
    cyc("idle5", 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);

    // Read and write together: write wins, read enable suppressed.
    cpu_if.re = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 32'h0000_9000; cpu_if.wdata = 16'hCAFE;
    mem_if.ready = 1'b1;
    cyc("dual", 32'h0000_9000, 16'hCAFE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    idle();
    cyc("idle6", 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);

    @(posedge clk); #1;
    chk("drain", "pending", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
